// File: rtl/operand_fetch.sv
// Operand fetch stage: register file with write-through bypass,
// immediate extension and a single registered operand slot.
module operand_fetch #(
    parameter int DATA_W = 16,
    parameter int AW     = 3,
    parameter int IMM_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     rs_addr,
    input  logic [AW-1:0]     rt_addr,
    input  logic [IMM_W-1:0]  imm,
    input  logic              use_imm,
    input  logic [1:0]        alu_op_in,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] operand_a,
    output logic [DATA_W-1:0] operand_b,
    output logic [1:0]        alu_op_out
);

    localparam int NREG = 2 ** AW;

    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] opb;
    logic              wr_hit;
    logic              accept;

    // r0 is never written, so it keeps its reset value of zero
    assign wr_hit = wb_en && (wb_addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        rd_a = regs[rs_addr];
        rd_b = regs[rt_addr];
        if (wr_hit && (wb_addr == rs_addr)) begin
            rd_a = wb_data;
        end
        if (wr_hit && (wb_addr == rt_addr)) begin
            rd_b = wb_data;
        end
    end

    assign imm_ext = {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
    assign opb     = use_imm ? imm_ext : rd_b;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            operand_a  <= '0;
            operand_b  <= '0;
            alu_op_out <= 2'b00;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            operand_a  <= rd_a;
            operand_b  <= opb;
            alu_op_out <= alu_op_in;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed table, hand-written corner
// sequences and random traffic against a behavioural model.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  rs_addr;
    logic [2:0]  rt_addr;
    logic [5:0]  imm;
    logic        use_imm;
    logic [1:0]  alu_op_in;
    logic        flush;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic [1:0]  alu_op_out;

    int errors = 0;
    int checks = 0;

    operand_fetch #(.DATA_W(16), .AW(3), .IMM_W(6)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .imm(imm), .use_imm(use_imm), .alu_op_in(alu_op_in),
        .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .operand_a(operand_a), .operand_b(operand_b),
        .alu_op_out(alu_op_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [5:0]  im;
        logic        ui;
        logic [1:0]  op;
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        ev;
        logic [15:0] ea;
        logic [15:0] eb;
        logic [1:0]  eop;
    } vec_t;

    vec_t tbl [8];

    int unsigned mregs [8];
    int unsigned ma, mb, mop;
    bit          mv;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        rs_addr   = 3'd0;
        rt_addr   = 3'd0;
        imm       = 6'd0;
        use_imm   = 1'b0;
        alu_op_in = 2'b00;
        flush     = 1'b0;
        wb_en     = 1'b0;
        wb_addr   = 3'd0;
        wb_data   = 16'h0;
        out_ready = 1'b1;
    endtask

    function automatic int unsigned mread(input int unsigned a);
        if (wb_en && wb_addr != 0 && int'(wb_addr) == a) return wb_data;
        if (a == 0) return 0;
        return mregs[a];
    endfunction

    function automatic int unsigned sext(input int unsigned v);
        int s;
        s = (v >= 32) ? int'(v) - 64 : int'(v);
        return int'(s) & 32'hFFFF;
    endfunction

    initial begin
        tbl[0] = '{1'b0, 3'd0, 3'd0, 6'd0, 1'b0, 2'd0,
                   1'b1, 3'd3, 16'h1234, 1'b0, 16'h0, 16'h0, 2'd0};
        tbl[1] = '{1'b1, 3'd3, 3'd0, 6'd0, 1'b0, 2'd0,
                   1'b0, 3'd0, 16'h0, 1'b1, 16'h1234, 16'h0, 2'd0};
        tbl[2] = '{1'b1, 3'd5, 3'd0, 6'd0, 1'b0, 2'd1,
                   1'b1, 3'd5, 16'hBEEF, 1'b1, 16'hBEEF, 16'h0, 2'd1};
        tbl[3] = '{1'b0, 3'd0, 3'd0, 6'd0, 1'b0, 2'd0,
                   1'b1, 3'd0, 16'hFFFF, 1'b0, 16'h0, 16'h0, 2'd0};
        tbl[4] = '{1'b1, 3'd0, 3'd0, 6'd0, 1'b0, 2'd2,
                   1'b1, 3'd0, 16'hFFFF, 1'b1, 16'h0, 16'h0, 2'd2};
        tbl[5] = '{1'b1, 3'd3, 3'd0, 6'b111110, 1'b1, 2'd3,
                   1'b0, 3'd0, 16'h0, 1'b1, 16'h1234, 16'hFFFE, 2'd3};
        tbl[6] = '{1'b1, 3'd5, 3'd0, 6'b011111, 1'b1, 2'd0,
                   1'b0, 3'd0, 16'h0, 1'b1, 16'hBEEF, 16'h001F, 2'd0};
        tbl[7] = '{1'b1, 3'd3, 3'd5, 6'd0, 1'b0, 2'd1,
                   1'b0, 3'd0, 16'h0, 1'b1, 16'h1234, 16'hBEEF, 2'd1};

        idle();
        rst = 1'b1;
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_a", operand_a, 0);
        chk("rst_b", operand_b, 0);
        chk("rst_op", alu_op_out, 0);
        tick();
        tick();
        #3;
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            in_valid  = tbl[i].iv;
            rs_addr   = tbl[i].rs;
            rt_addr   = tbl[i].rt;
            imm       = tbl[i].im;
            use_imm   = tbl[i].ui;
            alu_op_in = tbl[i].op;
            wb_en     = tbl[i].we;
            wb_addr   = tbl[i].wa;
            wb_data   = tbl[i].wd;
            out_ready = 1'b1;
            #1;
            chk($sformatf("tbl%0d_ready", i), in_ready, 1);
            tick();
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_a", i), operand_a, tbl[i].ea);
                chk($sformatf("tbl%0d_b", i), operand_b, tbl[i].eb);
                chk($sformatf("tbl%0d_op", i), alu_op_out, tbl[i].eop);
            end
        end

        // stall with writes to the held source register
        idle();
        wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'h0044;
        tick();
        chk("stall_pre_valid", out_valid, 0);
        idle();
        in_valid = 1'b1; rs_addr = 3'd4; alu_op_in = 2'd2;
        out_ready = 1'b0;
        tick();
        chk("stall_cap_valid", out_valid, 1);
        chk("stall_cap_a", operand_a, 16'h0044);
        alu_op_in = 2'd3;
        wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'h9999;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d_ready", k), in_ready, 0);
            tick();
            chk($sformatf("stall%0d_valid", k), out_valid, 1);
            chk($sformatf("stall%0d_a", k), operand_a, 16'h0044);
            chk($sformatf("stall%0d_b", k), operand_b, 16'h0000);
            chk($sformatf("stall%0d_op", k), alu_op_out, 2'd2);
        end
        wb_en = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("unstall_ready", in_ready, 1);
        tick();
        chk("unstall_valid", out_valid, 1);
        chk("unstall_a", operand_a, 16'h9999);
        chk("unstall_op", alu_op_out, 2'd3);

        // flush drops the offered instruction but not the write
        idle();
        in_valid = 1'b1; rs_addr = 3'd6; flush = 1'b1;
        wb_en = 1'b1; wb_addr = 3'd6; wb_data = 16'h0606;
        tick();
        chk("flush_valid", out_valid, 0);
        flush = 1'b0;
        wb_en = 1'b0;
        tick();
        chk("postflush_valid", out_valid, 1);
        chk("postflush_a", operand_a, 16'h0606);

        // asynchronous reset in the middle of a stall
        idle();
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h00AA;
        tick();
        idle();
        in_valid = 1'b1; rs_addr = 3'd2; alu_op_in = 2'd1;
        out_ready = 1'b0;
        tick();
        chk("rst2_hold_a", operand_a, 16'h00AA);
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_a", operand_a, 0);
        chk("arst_op", alu_op_out, 0);
        chk("arst_ready", in_ready, 1);
        in_valid = 1'b1;
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h5555;
        tick();
        chk("inrst_valid", out_valid, 0);
        #3;
        rst = 1'b0;
        idle();
        in_valid = 1'b1; rs_addr = 3'd2;
        tick();
        chk("postrst_valid", out_valid, 1);
        chk("postrst_r2", operand_a, 16'h0000);

        // random traffic against the model
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) mregs[i] = 0;
        mv = 0; ma = 0; mb = 0; mop = 0;
        for (int n = 0; n < 400; n++) begin
            int unsigned na, nb;
            bit acc, rdy;
            in_valid  = 1'($urandom_range(0, 1));
            rs_addr   = 3'($urandom_range(0, 7));
            rt_addr   = 3'($urandom_range(0, 7));
            imm       = 6'($urandom_range(0, 63));
            use_imm   = 1'($urandom_range(0, 1));
            alu_op_in = 2'($urandom_range(0, 3));
            flush     = ($urandom_range(0, 9) == 0);
            wb_en     = 1'($urandom_range(0, 1));
            wb_addr   = 3'($urandom_range(0, 7));
            wb_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            rdy = !mv || out_ready;
            chk("rnd_ready", in_ready, 32'(rdy));
            na = mread(rs_addr);
            nb = use_imm ? sext(imm) : mread(rt_addr);
            acc = in_valid && rdy && !flush;
            if (flush) mv = 0;
            else if (acc) begin
                mv = 1; ma = na; mb = nb; mop = alu_op_in;
            end else if (out_ready) mv = 0;
            if (wb_en && wb_addr != 0) mregs[wb_addr] = wb_data;
            tick();
            chk("rnd_valid", out_valid, 32'(mv));
            if (mv) begin
                chk("rnd_a", operand_a, ma);
                chk("rnd_b", operand_b, mb);
                chk("rnd_op", alu_op_out, mop);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath width of registers, operands and immediate extension.
REQ-002 SHALL have parameter AW, default 3, register address width (2**AW = 8 registers).
REQ-003 SHALL have parameter IMM_W, default 6, raw immediate field width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  decoded instruction fields are valid this cycle.
REQ-007 SHALL have port in_ready  output  1  stage accepts the instruction this cycle.
REQ-008 SHALL have port rs_addr  input  AW  source register A address.
REQ-009 SHALL have port rt_addr  input  AW  source register B address.
REQ-010 SHALL have port imm  input  IMM_W  two's-complement immediate.
REQ-011 SHALL have port use_imm  input  1  1 selects extended imm for operand B, 0 selects register rt.
REQ-012 SHALL have port alu_op_in  input  2  ALU control code (00 add, 01 sub, 10 and, 11 or), passed through.
REQ-013 SHALL have port flush  input  1  synchronous kill of the output slot.
REQ-014 SHALL have port wb_en  input  1  register write enable from write-back.
REQ-015 SHALL have port wb_addr  input  AW  write-back register address.
REQ-016 SHALL have port wb_data  input  DATA_W  write-back data (ALU answer).
REQ-017 SHALL have port out_valid  output  1  operand slot holds a valid instruction for the ALU.
REQ-018 SHALL have port out_ready  input  1  ALU side consumes the slot this cycle.
REQ-019 SHALL have port operand_a  output  DATA_W  registered ALU input1.
REQ-020 SHALL have port operand_b  output  DATA_W  registered ALU input2.
REQ-021 SHALL have port alu_op_out  output  2  registered ALU control.

Function
REQ-022 SHALL contain 2**AW registers of DATA_W bits; register 0 always reads 0; writes to it are discarded.
REQ-023 SHALL write wb_data into register wb_addr on the clk rising edge when wb_en=1 and wb_addr!=0, independent of handshake, stall or flush.
REQ-024 SHALL read both ports combinationally with write-through bypass: if wb_en=1, wb_addr!=0 and wb_addr equals the read address, the read value is wb_data (same-cycle write visible).
REQ-025 SHALL form operand B as use_imm ? sign-extend(imm to DATA_W) : read(rt_addr).
REQ-026 SHALL drive in_ready = !out_valid || out_ready (combinational; single output slot, no skid buffer).
REQ-027 SHALL capture operand_a, operand_b, alu_op_out and set out_valid=1 on a rising edge where in_valid && in_ready && !flush; latency exactly 1 cycle from acceptance to out_valid.
REQ-028 SHALL clear out_valid when out_ready=1 and no new capture occurs that edge.
REQ-029 SHALL hold operand_a, operand_b, alu_op_out and out_valid bit-stable while out_valid=1 and out_ready=0 (stall), including against subsequent register writes.
REQ-030 SHALL, when flush=1, clear out_valid at the next edge with priority over capture; an instruction offered in the flush cycle is dropped; data outputs may keep stale values.
REQ-031 SHALL support back-to-back throughput of one instruction per cycle while out_ready=1.

Reset
REQ-032 SHALL, while rst=1, asynchronously force all registers, operand_a, operand_b, alu_op_out to 0 and out_valid to 0 (in_ready therefore 1).
REQ-033 SHALL ignore wb_en and in_valid while rst=1; reset mid-stall discards the held slot.
REQ-034 SHALL resume normal operation on the first rising edge after rst deasserts.

Verification
REQ-035 SHALL test: after reset, write r3=0x1234 via wb; issue rs=3,rt=0,use_imm=0,op=00 -> next cycle out_valid=1, operand_a=0x1234, operand_b=0x0000, alu_op_out=00.
REQ-036 SHALL test: wb_en=1, wb_addr=5, wb_data=0xBEEF same cycle as accept of rs=5 -> operand_a=0xBEEF (bypass); wb to r0 of 0xFFFF then read r0 -> 0x0000.
REQ-037 SHALL test: use_imm=1, imm=6'b111110 -> operand_b=0xFFFE; imm=6'b011111 -> operand_b=0x001F.
REQ-038 SHALL test: out_ready=0 for 3 cycles with in_valid=1 and a wb to the source register -> in_ready=0, outputs unchanged for all 3 cycles; out_ready=1 -> next instruction captured next edge.
REQ-039 SHALL test: flush=1 in the cycle an instruction is accepted -> out_valid=0 next cycle; register writes in that cycle still land.
REQ-040 SHALL test: assert rst asynchronously (between edges) during a stall with r2=0x00AA -> out_valid and all outputs 0 immediately; r2 reads 0x0000 after release.
